imem_fetch_sequencer: RTL and testbench



---
 rtl/imem_fetch_sequencer.sv | 101 ++++++++++
 tb/tb_imem_fetch_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// Owns the PC, addresses the combinational instruction memory and hands each word to decode.
// Latency: start/redirect at edge N -> imem_addr updated after N, first word valid after N+1.
// Backpressure: out_valid && !out_ready holds pc and out_* stable; HALT word is never presented.
module imem_fetch_sequencer #(
   parameter int                      ADDR_WIDTH  = 8,
   parameter int                      INSTR_WIDTH = 32,
   parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = 32'hFFFF_FFFF,
   parameter int                      CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_addr,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_addr,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0]  out_pc,
   output logic                   busy,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   deliv_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  slot_free;
   logic                  handshake;
   logic                  is_halt;
   logic                  start_ok;

   assign slot_free = !out_valid || out_ready;
   assign handshake = out_valid && out_ready;
   assign is_halt   = (imem_rd == HALT_WORD);
   // start is only meaningful when fetch is not already running
   assign start_ok  = start && (state != ST_RUN);

   // imem_addr is the pc register itself, so memory address never depends on inputs this cycle
   assign imem_addr = pc;
   assign busy      = (state == ST_RUN);
   assign halted    = (state == ST_HALTED);

   // Fetch state machine: pc, output slot and run/halt state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  pc        <= start_addr;
                  out_valid <= 1'b0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (redirect_valid) begin
                  // held word (if any) is squashed; the target is fetched next cycle
                  pc        <= redirect_addr;
                  out_valid <= 1'b0;
               end else if (slot_free && is_halt) begin
                  // pc stays on the HALT word so software can see where fetch stopped
                  state     <= ST_HALTED;
                  out_valid <= 1'b0;
               end else if (slot_free) begin
                  out_instr <= imem_rd;
                  out_pc    <= pc;
                  out_valid <= 1'b1;
                  pc        <= pc + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Delivered-instruction counter: every completed handshake, cleared by an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         deliv_count <= '0;
      end else if (start_ok) begin
         deliv_count <= '0;
      end else if (handshake) begin
         deliv_count <= deliv_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed table-driven bench for imem_fetch_sequencer with a behavioural instruction memory.
// Each vector drives inputs, takes one rising edge, then compares outputs 1 time unit later.
// A short hand-written sequence covers throughput, input isolation of imem_addr and reset priority.
module tb_imem_fetch_sequencer;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] A0 = 32'hA0A0_0000;
   localparam logic [31:0] A1 = 32'hA0A0_0001;
   localparam logic [31:0] A2 = 32'hA0A0_0002;
   localparam logic [31:0] A3 = 32'hA0A0_0003;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  start_addr;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic        busy;
   logic        halted;
   logic [15:0] deliv_count;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   imem_fetch_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_addr(imem_addr), .imem_rd(imem_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .busy(busy), .halted(halted), .deliv_count(deliv_count)
   );

   always #5 clk = ~clk;

   always_comb imem_rd = mem[imem_addr];

   typedef struct {
      logic        r, s;
      logic [7:0]  sa;
      logic        rv;
      logic [7:0]  ra;
      logic        rdy;
      logic        pk;
      logic [7:0]  pa;
      logic [31:0] pd;
      logic        ov;
      logic [31:0] oi;
      logic [7:0]  op, ia;
      logic        bz, ht;
      logic [15:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] cw(input logic [7:0] a);
      return 32'hC000_0000 | {24'h0, a};
   endfunction

   // inputs: rst start sa rv ra rdy | expected: ov oi op ia busy halted cnt
   function automatic vec_t mk(input logic r, s, input logic [7:0] sa, input logic rv,
                               input logic [7:0] ra, input logic rdy, input logic ov,
                               input logic [31:0] oi, input logic [7:0] op, ia,
                               input logic bz, ht, input logic [15:0] cnt);
      vec_t v;
      v.r = r; v.s = s; v.sa = sa; v.rv = rv; v.ra = ra; v.rdy = rdy;
      v.pk = 1'b0; v.pa = 8'h00; v.pd = 32'h0;
      v.ov = ov; v.oi = oi; v.op = op; v.ia = ia; v.bz = bz; v.ht = ht; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      for (int a = 0; a < 256; a++) mem[a] = cw(a[7:0]);
      mem[0] = A0; mem[1] = A1; mem[2] = A2; mem[3] = A3; mem[4] = HALT;

      // reset, redirect ignored in IDLE
      vq.push_back(mk(1,0,8'h00,0,8'h00,0, 0,32'h0,8'h00,8'h00,0,0,16'd0));
      vq.push_back(mk(1,0,8'h00,0,8'h00,0, 0,32'h0,8'h00,8'h00,0,0,16'd0));
      vq.push_back(mk(0,0,8'h00,1,8'h20,0, 0,32'h0,8'h00,8'h00,0,0,16'd0));
      // straight-line 0..3 then HALT at 4
      vq.push_back(mk(0,1,8'h00,0,8'h00,1, 0,32'h0,8'h00,8'h00,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A0,8'h00,8'h01,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A2,8'h02,8'h03,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A3,8'h03,8'h04,1,0,16'd3));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 0,A3,8'h03,8'h04,0,1,16'd4));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 0,A3,8'h03,8'h04,0,1,16'd4));
      // back-pressure on out_pc=1 for three cycles
      vq.push_back(mk(0,1,8'h00,0,8'h00,1, 0,A3,8'h03,8'h00,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A0,8'h00,8'h01,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,0, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,0, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,0, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A2,8'h02,8'h03,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A3,8'h03,8'h04,1,0,16'd3));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 0,A3,8'h03,8'h04,0,1,16'd4));
      // redirect while out_pc=2 stalled: word dropped, uncounted
      vq.push_back(mk(0,1,8'h00,0,8'h00,1, 0,A3,8'h03,8'h00,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A0,8'h00,8'h01,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A1,8'h01,8'h02,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A2,8'h02,8'h03,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,1,8'h20,0, 0,A2,8'h02,8'h20,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,cw(8'h20),8'h20,8'h21,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,cw(8'h21),8'h21,8'h22,1,0,16'd3));
      // redirect with out_ready high: handshake still counts
      vq.push_back(mk(0,0,8'h00,1,8'h03,1, 0,cw(8'h21),8'h21,8'h03,1,0,16'd4));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A3,8'h03,8'h04,1,0,16'd4));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 0,A3,8'h03,8'h04,0,1,16'd5));
      // redirect ignored in HALTED
      vq.push_back(mk(0,0,8'h00,1,8'h40,1, 0,A3,8'h03,8'h04,0,1,16'd5));
      // wrap FE,FF,00 then HALT at 01 (memory poked first)
      v = mk(0,1,8'hFE,0,8'h00,1, 0,A3,8'h03,8'hFE,1,0,16'd0);
      v.pk = 1'b1; v.pa = 8'h01; v.pd = HALT;
      vq.push_back(v);
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,cw(8'hFE),8'hFE,8'hFF,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,cw(8'hFF),8'hFF,8'h00,1,0,16'd1));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,A0,8'h00,8'h01,1,0,16'd2));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 0,A0,8'h00,8'h01,0,1,16'd3));
      // restart from HALTED at 0x10
      vq.push_back(mk(0,1,8'h10,0,8'h00,1, 0,A0,8'h00,8'h10,1,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,1, 1,cw(8'h10),8'h10,8'h11,1,0,16'd0));
      // stall with start in RUN (ignored)
      vq.push_back(mk(0,1,8'h50,0,8'h00,0, 1,cw(8'h10),8'h10,8'h11,1,0,16'd0));
      // reset mid-stall
      vq.push_back(mk(1,0,8'h00,0,8'h00,0, 0,32'h0,8'h00,8'h00,0,0,16'd0));
      vq.push_back(mk(0,0,8'h00,0,8'h00,0, 0,32'h0,8'h00,8'h00,0,0,16'd0));

      rst = 1'b1; start = 1'b0; start_addr = 8'h00;
      redirect_valid = 1'b0; redirect_addr = 8'h00; out_ready = 1'b0;

      foreach (vq[i]) begin
         if (vq[i].pk) mem[vq[i].pa] = vq[i].pd;
         rst = vq[i].r; start = vq[i].s; start_addr = vq[i].sa;
         redirect_valid = vq[i].rv; redirect_addr = vq[i].ra; out_ready = vq[i].rdy;
         step();
         chk("out_valid",   i, {31'h0, out_valid},  {31'h0, vq[i].ov});
         chk("out_instr",   i, out_instr,           vq[i].oi);
         chk("out_pc",      i, {24'h0, out_pc},     {24'h0, vq[i].op});
         chk("imem_addr",   i, {24'h0, imem_addr},  {24'h0, vq[i].ia});
         chk("busy",        i, {31'h0, busy},       {31'h0, vq[i].bz});
         chk("halted",      i, {31'h0, halted},     {31'h0, vq[i].ht});
         chk("deliv_count", i, {16'h0, deliv_count},{16'h0, vq[i].cnt});
      end

      // hand sequence: start at 5, imem_addr isolated from inputs, full throughput
      rst = 1'b0; start = 1'b1; start_addr = 8'h05; redirect_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("seq_start_addr", 100, {24'h0, imem_addr}, 32'h5);
      start = 1'b0; start_addr = 8'h77; redirect_addr = 8'h66;
      #2;
      chk("seq_addr_isolated", 101, {24'h0, imem_addr}, 32'h5);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("seq_tp_valid", 102 + k, {31'h0, out_valid}, 32'h1);
         chk("seq_tp_pc",    102 + k, {24'h0, out_pc}, 32'(5 + k));
         chk("seq_tp_instr", 102 + k, out_instr, cw(8'(5 + k)));
         chk("seq_tp_cnt",   102 + k, {16'h0, deliv_count}, 32'(k));
      end
      // reset wins over simultaneous start and redirect
      rst = 1'b1; start = 1'b1; start_addr = 8'h33; redirect_valid = 1'b1; redirect_addr = 8'h44;
      step();
      chk("seq_rst_valid", 110, {31'h0, out_valid}, 32'h0);
      chk("seq_rst_busy",  110, {31'h0, busy}, 32'h0);
      chk("seq_rst_addr",  110, {24'h0, imem_addr}, 32'h0);
      chk("seq_rst_cnt",   110, {16'h0, deliv_count}, 32'h0);
      rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
